// File: rtl/uart_tx.sv
// Even-parity UART transmitter (8E1) with a one-byte holding register so the
// next frame can be queued while the current one shifts out.
module uart_tx #(
  parameter int unsigned CYCLES_PER_BIT = 14
) (
  input  logic       clk_3125,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_ready,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned BIT_W = 3;
  localparam logic [CNT_W-1:0] CYC_LAST = CNT_W'(CYCLES_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(7);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cyc_cnt;
  logic [BIT_W-1:0] bit_cnt;
  logic [7:0]       shift_reg;
  logic [7:0]       buf_data;
  logic             buf_full;
  logic             parity;
  logic             bit_end_c;
  logic             accept_c;
  logic             load_c;

  // Load happens from IDLE or on the final STOP cycle; accept needs an empty buffer.
  always_comb begin
    bit_end_c = (cyc_cnt == CYC_LAST);
    accept_c  = tx_start && tx_ready;
    load_c    = buf_full && ((state == IDLE) || ((state == STOP) && bit_end_c));
  end

  always_ff @(posedge clk_3125) begin
    if (!rst_n) begin
      state     <= IDLE;
      cyc_cnt   <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      buf_data  <= '0;
      buf_full  <= 1'b0;
      parity    <= 1'b0;
      tx        <= 1'b1;
      tx_busy   <= 1'b0;
      tx_done   <= 1'b0;
      tx_ready  <= 1'b1;
    end else begin
      tx_done <= 1'b0;
      cyc_cnt <= bit_end_c ? '0 : cyc_cnt + CNT_W'(1);

      // tx_ready is kept as the registered complement of buf_full
      if (accept_c) begin
        buf_data <= tx_data;
        buf_full <= 1'b1;
        tx_ready <= 1'b0;
      end else if (load_c) begin
        buf_full <= 1'b0;
        tx_ready <= 1'b1;
      end

      if (load_c) begin
        shift_reg <= buf_data;
        parity    <= ^buf_data;
      end

      case (state)
        IDLE: begin
          cyc_cnt <= '0;
          bit_cnt <= '0;
          tx      <= 1'b1;
          tx_busy <= 1'b0;
          if (load_c) begin
            state   <= START;
            tx      <= 1'b0;
            tx_busy <= 1'b1;
          end
        end
        START: begin
          if (bit_end_c) begin
            state <= DATA;
            tx    <= shift_reg[0];
          end
        end
        DATA: begin
          if (bit_end_c) begin
            if (bit_cnt == BIT_LAST) begin
              state   <= PARITY;
              bit_cnt <= '0;
              tx      <= parity;
            end else begin
              bit_cnt   <= bit_cnt + BIT_W'(1);
              shift_reg <= shift_reg >> 1;
              tx        <= shift_reg[1];
            end
          end
        end
        PARITY: begin
          if (bit_end_c) begin
            state <= STOP;
            tx    <= 1'b1;
          end
        end
        STOP: begin
          if (bit_end_c) begin
            tx_done <= 1'b1;
            if (load_c) begin
              state <= START;
              tx    <= 1'b0;
            end else begin
              state   <= IDLE;
              tx      <= 1'b1;
              tx_busy <= 1'b0;
            end
          end
        end
        default: begin
          state   <= IDLE;
          cyc_cnt <= '0;
          bit_cnt <= '0;
          tx      <= 1'b1;
          tx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: stimulus queues expected frames, a line monitor
// decodes tx like the paired receiver and checks each frame against the queue.
module tb_uart_tx;

  localparam int unsigned CPB   = 14;
  localparam int          FRAME = 11 * CPB;

  logic       clk_3125 = 1'b0;
  logic       rst_n;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_ready;
  logic       tx;
  logic       tx_busy;
  logic       tx_done;

  uart_tx #(.CYCLES_PER_BIT(CPB)) dut (
    .clk_3125 (clk_3125),
    .rst_n    (rst_n),
    .tx_data  (tx_data),
    .tx_start (tx_start),
    .tx_ready (tx_ready),
    .tx       (tx),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done)
  );

  always #5 clk_3125 = ~clk_3125;

  typedef struct packed {
    logic [7:0] data;
    logic       par;
    logic       b2b;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Line monitor / receiver model
  int          k        = -1;
  int          idle_cnt = 0;
  int          last_gap = 0;
  int          done_cnt = 0;
  logic [10:0] bits;
  logic        busy_bad;
  logic        done_bad;
  logic        have_exp;
  exp_t        cur;

  task automatic frame_start();
    k        = 0;
    busy_bad = 1'b0;
    done_bad = 1'b0;
    bits     = '0;
    if (q.size() == 0) begin
      total++;
      bad++;
      have_exp = 1'b0;
      $display("FAIL unexpected_frame: got frame want none at %0t", $time);
    end else begin
      have_exp = 1'b1;
      cur = q.pop_front();
      if (cur.b2b) chk("b2b_gap", last_gap, 0);
    end
  endtask

  always @(negedge clk_3125) begin
    if (tx_done === 1'b1) done_cnt++;
    if (rst_n !== 1'b1) begin
      k        = -1;
      idle_cnt = 0;
    end else if (k == FRAME) begin
      chk("done_pulse", tx_done, 1);
      if (tx === 1'b0) begin
        last_gap = 0;
        frame_start();
      end else begin
        k        = -1;
        idle_cnt = 1;
      end
    end else if (k < 0) begin
      if (tx === 1'b0) begin
        last_gap = idle_cnt;
        idle_cnt = 0;
        frame_start();
      end else begin
        idle_cnt++;
      end
    end
    if (k >= 0 && k < FRAME) begin
      if (k % CPB == CPB / 2) bits[k / CPB] = tx;
      if (tx_busy !== 1'b1) busy_bad = 1'b1;
      if (k >= 1 && tx_done !== 1'b0) done_bad = 1'b1;
      if (k == FRAME - 1 && have_exp) begin
        chk("start_bit", bits[0], 0);
        chk("data", bits[8:1], cur.data);
        chk("parity", bits[9], cur.par);
        chk("stop_bit", bits[10], 1);
        chk("busy_in_frame", busy_bad, 0);
        chk("done_in_frame", done_bad, 0);
      end
      k++;
    end
  end

  task automatic send(input logic [7:0] d, input logic p, input logic b2b);
    int n;
    n = 0;
    @(negedge clk_3125);
    while (tx_ready !== 1'b1 && n < 2000) begin
      @(negedge clk_3125);
      n++;
    end
    if (n >= 2000) chk("ready_timeout", tx_ready, 1);
    q.push_back('{data: d, par: p, b2b: b2b});
    tx_data  = d;
    tx_start = 1'b1;
    @(posedge clk_3125);
    #1 tx_start = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    repeat (2) @(negedge clk_3125);
    while ((tx_busy !== 1'b0 || tx_ready !== 1'b1) && n < 3000) begin
      @(negedge clk_3125);
      n++;
    end
    if (n >= 3000) chk("idle_timeout", tx_busy, 0);
    repeat (3) @(negedge clk_3125);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n    = 1'b0;
    tx_start = 1'b0;
    tx_data  = 8'h00;
    repeat (3) @(posedge clk_3125);
    @(negedge clk_3125);
    chk("rst_tx", tx, 1);
    chk("rst_busy", tx_busy, 0);
    chk("rst_done", tx_done, 0);
    chk("rst_ready", tx_ready, 1);
    @(posedge clk_3125);
    #1 rst_n = 1'b1;

    // Single byte from idle: one-clock latency to the start bit
    send(8'hA5, 1'b0, 1'b0);
    @(negedge clk_3125);
    chk("accept_ready", tx_ready, 0);
    chk("accept_tx_idle", tx, 1);
    @(negedge clk_3125);
    chk("load_tx", tx, 0);
    chk("load_busy", tx_busy, 1);
    chk("load_ready", tx_ready, 1);
    wait_idle();

    // Odd number of ones -> parity bit set
    send(8'h07, 1'b1, 1'b0);
    wait_idle();

    // Back-to-back plus overflow attempt while the buffer is full
    send(8'h55, 1'b0, 1'b0);
    repeat (30) @(negedge clk_3125);
    send(8'hAA, 1'b0, 1'b1);
    @(negedge clk_3125);
    chk("queued_ready", tx_ready, 0);
    tx_data  = 8'h11;
    tx_start = 1'b1;
    @(posedge clk_3125);
    #1 tx_start = 1'b0;
    repeat (60) @(negedge clk_3125);
    chk("still_full_ready", tx_ready, 0);
    wait_idle();

    // Reset during DATA bit 3 of 0xF0 aborts the frame
    send(8'hF0, 1'b0, 1'b0);
    n = 0;
    while (tx !== 1'b0 && n < 100) begin
      @(negedge clk_3125);
      n++;
    end
    if (n >= 100) chk("f0_start_timeout", tx, 0);
    repeat (59) @(negedge clk_3125);
    @(posedge clk_3125);
    #1 rst_n = 1'b0;
    @(posedge clk_3125);
    @(negedge clk_3125);
    chk("midrst_tx", tx, 1);
    chk("midrst_busy", tx_busy, 0);
    chk("midrst_ready", tx_ready, 1);
    chk("midrst_done", tx_done, 0);
    @(posedge clk_3125);
    #1 rst_n = 1'b1;
    send(8'h3C, 1'b0, 1'b0);
    wait_idle();

    // Loopback burst
    send(8'h00, 1'b0, 1'b0);
    send(8'hFF, 1'b0, 1'b1);
    send(8'h3C, 1'b0, 1'b1);
    wait_idle();
    repeat (5) @(negedge clk_3125);

    chk("queue_empty", q.size(), 0);
    chk("done_count", done_cnt, 8);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
